// File: rtl/ahbl_arbiter.sv
// ahbl_arbiter: round-robin arbiter and multiplexer that lets NUM_MST AHB-Lite
// masters share one AHB-Lite slave port. A master that loses arbitration has its
// address phase parked in a one-entry holding register and is stalled through its
// own hready. The block also owns the bridge clock-ratio setting and applies it
// only while the shared bus is quiescent.
module ahbl_arbiter #(
   parameter int         NUM_MST       = 2,
   parameter logic [3:0] CLK_RATIO_RST = 4'd1
) (
   input  logic                   hclk,
   input  logic                   hreset,
   // master ports, slice i belongs to master i
   input  logic [NUM_MST-1:0]     m_hsel,
   input  logic [32*NUM_MST-1:0]  m_haddr,
   input  logic [2*NUM_MST-1:0]   m_htrans,
   input  logic [3*NUM_MST-1:0]   m_hsize,
   input  logic [3*NUM_MST-1:0]   m_hburst,
   input  logic [4*NUM_MST-1:0]   m_hprot,
   input  logic [NUM_MST-1:0]     m_hwrite,
   input  logic [32*NUM_MST-1:0]  m_hwdata,
   output logic [32*NUM_MST-1:0]  m_hrdata,
   output logic [NUM_MST-1:0]     m_hready,
   output logic [NUM_MST-1:0]     m_hresp,
   // shared slave port
   output logic                   s_hsel,
   output logic [31:0]            s_haddr,
   output logic [1:0]             s_htrans,
   output logic [2:0]             s_hsize,
   output logic [2:0]             s_hburst,
   output logic [3:0]             s_hprot,
   output logic                   s_hwrite,
   output logic [31:0]            s_hwdata,
   input  logic [31:0]            s_hrdata,
   input  logic                   s_hready,
   input  logic                   s_hresp,
   // clock-ratio configuration
   input  logic [3:0]             cfg_clk_ratio,
   input  logic                   cfg_clk_ratio_vld,
   output logic [3:0]             s_clk_ratio
);

   localparam int IW = (NUM_MST > 2) ? 2 : 1;

   localparam logic [1:0] HT_BUSY = 2'b01;
   localparam logic [1:0] HT_SEQ  = 2'b11;

   // one complete address phase as seen on an AHB-Lite port
   typedef struct packed {
      logic        sel;
      logic [31:0] addr;
      logic [1:0]  trans;
      logic [2:0]  size;
      logic [2:0]  burst;
      logic [3:0]  prot;
      logic        write;
   } ap_t;

   ap_t               live_ap [NUM_MST];
   ap_t               src_ap  [NUM_MST];
   ap_t               hold_q  [NUM_MST];
   ap_t               hold_d  [NUM_MST];
   logic [31:0]       m_wdata [NUM_MST];
   ap_t               out_q, out_d;

   logic [NUM_MST-1:0] pend_q, pend_d;
   logic [NUM_MST-1:0] live_req, req, own_dp;
   logic [IW-1:0]      rr_last_q, rr_last_d;
   logic [IW-1:0]      dp_own_q, dp_own_d;
   logic [IW-1:0]      win_idx, cand;
   logic               dp_vld_q, dp_vld_d;
   logic               win_vld, lock, grant, quiet;
   logic [3:0]         shadow_q, shadow_d;
   logic [3:0]         ratio_q, ratio_d;
   logic               ratio_pend_q, ratio_pend_d;

   genvar gi;
   generate
      for (gi = 0; gi < NUM_MST; gi++) begin : g_mst
         assign live_ap[gi] = {m_hsel[gi], m_haddr[gi*32 +: 32], m_htrans[gi*2 +: 2],
                               m_hsize[gi*3 +: 3], m_hburst[gi*3 +: 3],
                               m_hprot[gi*4 +: 4], m_hwrite[gi]};
         assign m_wdata[gi]  = m_hwdata[gi*32 +: 32];
         // only the data-phase owner sees the slave response
         assign own_dp[gi]   = dp_vld_q && (dp_own_q == IW'(gi));
         assign m_hready[gi] = own_dp[gi] ? s_hready : ~pend_q[gi];
         assign m_hresp[gi]  = own_dp[gi] & s_hresp;
         assign m_hrdata[gi*32 +: 32] = own_dp[gi] ? s_hrdata : 32'h0;
         // a live request is only sampled while the master itself sees hready high
         assign live_req[gi] = ~pend_q[gi] & m_hready[gi] & m_hsel[gi] & m_htrans[gi*2+1];
         assign req[gi]      = pend_q[gi] | live_req[gi];
         assign src_ap[gi]   = pend_q[gi] ? hold_q[gi] : live_ap[gi];
      end
   endgenerate

   // the data-phase owner keeps the bus while its next beat continues the burst
   assign lock = dp_vld_q && src_ap[dp_own_q].sel &&
                 ((src_ap[dp_own_q].trans == HT_SEQ) || (src_ap[dp_own_q].trans == HT_BUSY)) &&
                 (pend_q[dp_own_q] || m_hready[dp_own_q]);

   assign grant = s_hready & win_vld;
   assign quiet = ~dp_vld_q && (pend_q == '0) && (req == '0);

   // winner selection: burst lock first, then round-robin from rr_last+1
   always_comb begin
      win_vld = 1'b0;
      win_idx = rr_last_q;
      cand    = '0;
      if (lock) begin
         win_vld = 1'b1;
         win_idx = dp_own_q;
      end else begin
         // walk downwards so the nearest candidate after rr_last is assigned last
         for (int k = NUM_MST; k >= 1; k--) begin
            cand = IW'((int'(rr_last_q) + k) % NUM_MST);
            if (req[cand]) begin
               win_vld = 1'b1;
               win_idx = cand;
            end
         end
      end
   end

   // slave address phase: live winner when ready, otherwise frozen through the stall
   always_comb begin
      out_d = out_q;
      if (s_hready) begin
         out_d = win_vld ? src_ap[win_idx] : '0;
      end
   end

   // holding registers: park losers and stalled requests, release on grant
   always_comb begin
      pend_d = pend_q;
      hold_d = hold_q;
      for (int i = 0; i < NUM_MST; i++) begin
         if (grant && (win_idx == IW'(i))) begin
            pend_d[i] = 1'b0;
         end else if (live_req[i]) begin
            pend_d[i] = 1'b1;
            hold_d[i] = live_ap[i];
         end
      end
   end

   // round-robin pointer and data-phase owner advance with each accepted address phase
   always_comb begin
      rr_last_d = rr_last_q;
      dp_vld_d  = dp_vld_q;
      dp_own_d  = dp_own_q;
      if (s_hready) begin
         dp_vld_d = win_vld;
         if (win_vld) begin
            rr_last_d = win_idx;
            dp_own_d  = win_idx;
         end
      end
   end

   // clock ratio: shadow the latest strobe, apply it on the first quiet cycle
   always_comb begin
      shadow_d     = shadow_q;
      ratio_d      = ratio_q;
      ratio_pend_d = ratio_pend_q;
      if (ratio_pend_q && quiet) begin
         ratio_d      = shadow_q;
         ratio_pend_d = 1'b0;
      end
      if (cfg_clk_ratio_vld) begin
         shadow_d     = cfg_clk_ratio;
         ratio_pend_d = 1'b1;
      end
   end

   // state registers with synchronous reset
   always_ff @(posedge hclk) begin
      if (hreset) begin
         pend_q       <= '0;
         rr_last_q    <= IW'(NUM_MST - 1);
         dp_own_q     <= '0;
         dp_vld_q     <= 1'b0;
         out_q        <= '0;
         shadow_q     <= CLK_RATIO_RST;
         ratio_q      <= CLK_RATIO_RST;
         ratio_pend_q <= 1'b0;
         for (int i = 0; i < NUM_MST; i++) begin
            hold_q[i] <= '0;
         end
      end else begin
         pend_q       <= pend_d;
         rr_last_q    <= rr_last_d;
         dp_own_q     <= dp_own_d;
         dp_vld_q     <= dp_vld_d;
         out_q        <= out_d;
         shadow_q     <= shadow_d;
         ratio_q      <= ratio_d;
         ratio_pend_q <= ratio_pend_d;
         for (int i = 0; i < NUM_MST; i++) begin
            hold_q[i] <= hold_d[i];
         end
      end
   end

   assign s_hsel      = out_d.sel;
   assign s_haddr     = out_d.addr;
   assign s_htrans    = out_d.trans;
   assign s_hsize     = out_d.size;
   assign s_hburst    = out_d.burst;
   assign s_hprot     = out_d.prot;
   assign s_hwrite    = out_d.write;
   assign s_hwdata    = dp_vld_q ? m_wdata[dp_own_q] : 32'h0;
   assign s_clk_ratio = ratio_q;

endmodule

// File: tb/tb_ahbl_arbiter.sv
// tb_ahbl_arbiter: scenario-driven bench for the two-master AHB-Lite arbiter.
// Each scenario pushes the slave address phases it expects into a queue; a
// monitor records every address phase the slave accepts, and each scenario
// drains both queues in order at its end.
module tb_ahbl_arbiter;

   localparam logic [1:0] IDLE = 2'b00, NS = 2'b10, SQ = 2'b11;
   localparam logic [2:0] SINGLE = 3'b000, INCR4 = 3'b011;

   logic        hclk = 1'b0;
   logic        hreset;
   logic [1:0]  m_hsel;
   logic [63:0] m_haddr;
   logic [3:0]  m_htrans;
   logic [5:0]  m_hsize;
   logic [5:0]  m_hburst;
   logic [7:0]  m_hprot;
   logic [1:0]  m_hwrite;
   logic [63:0] m_hwdata;
   logic [63:0] m_hrdata;
   logic [1:0]  m_hready;
   logic [1:0]  m_hresp;
   logic        s_hsel;
   logic [31:0] s_haddr;
   logic [1:0]  s_htrans;
   logic [2:0]  s_hsize;
   logic [2:0]  s_hburst;
   logic [3:0]  s_hprot;
   logic        s_hwrite;
   logic [31:0] s_hwdata;
   logic [31:0] s_hrdata;
   logic        s_hready;
   logic        s_hresp;
   logic [3:0]  cfg_clk_ratio;
   logic        cfg_clk_ratio_vld;
   logic [3:0]  s_clk_ratio;

   int pass_cnt  = 0;
   int total_cnt = 0;

   logic [32:0] exp_q[$];
   logic [32:0] obs_q[$];

   ahbl_arbiter #(.NUM_MST(2), .CLK_RATIO_RST(4'd1)) dut (
      .hclk(hclk), .hreset(hreset),
      .m_hsel(m_hsel), .m_haddr(m_haddr), .m_htrans(m_htrans), .m_hsize(m_hsize),
      .m_hburst(m_hburst), .m_hprot(m_hprot), .m_hwrite(m_hwrite), .m_hwdata(m_hwdata),
      .m_hrdata(m_hrdata), .m_hready(m_hready), .m_hresp(m_hresp),
      .s_hsel(s_hsel), .s_haddr(s_haddr), .s_htrans(s_htrans), .s_hsize(s_hsize),
      .s_hburst(s_hburst), .s_hprot(s_hprot), .s_hwrite(s_hwrite), .s_hwdata(s_hwdata),
      .s_hrdata(s_hrdata), .s_hready(s_hready), .s_hresp(s_hresp),
      .cfg_clk_ratio(cfg_clk_ratio), .cfg_clk_ratio_vld(cfg_clk_ratio_vld),
      .s_clk_ratio(s_clk_ratio)
   );

   always #5 hclk = ~hclk;

   // record every address phase the slave accepts
   always @(negedge hclk) begin
      if (!hreset && s_hready && s_hsel && s_htrans[1])
         obs_q.push_back({s_hwrite, s_haddr});
   end

   task automatic tick();
      @(posedge hclk);
      #1;
   endtask

   task automatic smp();
      @(negedge hclk);
   endtask

   task automatic drive_m(input int i, input logic sel, input logic [1:0] tr,
                          input logic [31:0] a, input logic w, input logic [2:0] b);
      m_hsel[i]            = sel;
      m_htrans[i*2 +: 2]   = tr;
      m_haddr[i*32 +: 32]  = a;
      m_hwrite[i]          = w;
      m_hburst[i*3 +: 3]   = b;
      m_hsize[i*3 +: 3]    = 3'b010;
      m_hprot[i*4 +: 4]    = 4'b0011;
   endtask

   task automatic idle_m(input int i);
      drive_m(i, 1'b0, IDLE, 32'h0, 1'b0, SINGLE);
   endtask

   task automatic test_reset();
      hreset = 1'b1;
      idle_m(0); idle_m(1);
      m_hwdata = '0; s_hrdata = 32'h1234_5678; s_hready = 1'b1; s_hresp = 1'b0;
      cfg_clk_ratio = 4'd0; cfg_clk_ratio_vld = 1'b0;
      tick(); tick(); smp();
      total_cnt++; if (s_hsel !== 1'b0) $display("FAIL rst_hsel got=%b exp=0", s_hsel); else pass_cnt++;
      total_cnt++; if (s_htrans !== IDLE) $display("FAIL rst_htrans got=%b exp=00", s_htrans); else pass_cnt++;
      total_cnt++; if (s_haddr !== 32'h0) $display("FAIL rst_haddr got=%h exp=0", s_haddr); else pass_cnt++;
      total_cnt++; if (m_hready !== 2'b11) $display("FAIL rst_mhready got=%b exp=11", m_hready); else pass_cnt++;
      total_cnt++; if (m_hresp !== 2'b00) $display("FAIL rst_mhresp got=%b exp=00", m_hresp); else pass_cnt++;
      total_cnt++; if (m_hrdata !== 64'h0) $display("FAIL rst_mhrdata got=%h exp=0", m_hrdata); else pass_cnt++;
      total_cnt++; if (s_clk_ratio !== 4'd1) $display("FAIL rst_ratio got=%0d exp=1", s_clk_ratio); else pass_cnt++;
      tick(); hreset = 1'b0;
      $display("test_reset done");
   endtask

   task automatic test_single_write();
      logic [32:0] e, o;
      tick(); drive_m(0, 1'b1, NS, 32'h1000, 1'b1, SINGLE); exp_q.push_back({1'b1, 32'h1000});
      smp();
      total_cnt++; if (s_haddr !== 32'h1000) $display("FAIL sw_addr got=%h exp=00001000", s_haddr); else pass_cnt++;
      total_cnt++; if (m_hready[0] !== 1'b1) $display("FAIL sw_rdy0 got=%b exp=1", m_hready[0]); else pass_cnt++;
      tick(); idle_m(0); m_hwdata[31:0] = 32'hA5A5_0001;
      smp();
      total_cnt++; if (s_hwdata !== 32'hA5A5_0001) $display("FAIL sw_wdata got=%h exp=a5a50001", s_hwdata); else pass_cnt++;
      total_cnt++; if (m_hready[0] !== 1'b1) $display("FAIL sw_rdy0_dp got=%b exp=1", m_hready[0]); else pass_cnt++;
      tick(); smp();
      total_cnt++; if (m_hready[0] !== 1'b1) $display("FAIL sw_rdy0_end got=%b exp=1", m_hready[0]); else pass_cnt++;
      tick();
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); total_cnt++;
         if (obs_q.size() == 0) $display("FAIL sw_sb got=none exp=%h", e);
         else begin o = obs_q.pop_front(); if (o !== e) $display("FAIL sw_sb got=%h exp=%h", o, e); else pass_cnt++; end
      end
      total_cnt++; if (obs_q.size() != 0) $display("FAIL sw_sb_extra got=%0d exp=0", obs_q.size()); else pass_cnt++;
      obs_q.delete();
      $display("test_single_write done");
   endtask

   task automatic test_tie();
      logic [32:0] e, o;
      hreset = 1'b1; tick(); hreset = 1'b0;
      tick();
      drive_m(0, 1'b1, NS, 32'h1100, 1'b0, SINGLE); exp_q.push_back({1'b0, 32'h1100});
      drive_m(1, 1'b1, NS, 32'h1200, 1'b0, SINGLE); exp_q.push_back({1'b0, 32'h1200});
      smp();
      total_cnt++; if (s_haddr !== 32'h1100) $display("FAIL tie1_addr got=%h exp=00001100", s_haddr); else pass_cnt++;
      total_cnt++; if (m_hready !== 2'b11) $display("FAIL tie1_rdy got=%b exp=11", m_hready); else pass_cnt++;
      tick();
      drive_m(0, 1'b1, NS, 32'h1104, 1'b0, SINGLE); exp_q.push_back({1'b0, 32'h1104});
      idle_m(1);
      smp();
      total_cnt++; if (s_haddr !== 32'h1200) $display("FAIL tie2_addr got=%h exp=00001200", s_haddr); else pass_cnt++;
      total_cnt++; if (m_hready !== 2'b01) $display("FAIL tie2_rdy got=%b exp=01", m_hready); else pass_cnt++;
      tick(); idle_m(0);
      smp();
      total_cnt++; if (s_haddr !== 32'h1104) $display("FAIL tie3_addr got=%h exp=00001104", s_haddr); else pass_cnt++;
      total_cnt++; if (m_hready !== 2'b10) $display("FAIL tie3_rdy got=%b exp=10", m_hready); else pass_cnt++;
      tick(); smp();
      total_cnt++; if (s_htrans !== IDLE) $display("FAIL tie4_htrans got=%b exp=00", s_htrans); else pass_cnt++;
      total_cnt++; if (m_hready !== 2'b11) $display("FAIL tie4_rdy got=%b exp=11", m_hready); else pass_cnt++;
      tick();
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); total_cnt++;
         if (obs_q.size() == 0) $display("FAIL tie_sb got=none exp=%h", e);
         else begin o = obs_q.pop_front(); if (o !== e) $display("FAIL tie_sb got=%h exp=%h", o, e); else pass_cnt++; end
      end
      total_cnt++; if (obs_q.size() != 0) $display("FAIL tie_sb_extra got=%0d exp=0", obs_q.size()); else pass_cnt++;
      obs_q.delete();
      $display("test_tie done");
   endtask

   task automatic test_burst_lock();
      logic [32:0] e, o;
      tick(); drive_m(1, 1'b1, NS, 32'h2000, 1'b0, INCR4); exp_q.push_back({1'b0, 32'h2000});
      smp();
      total_cnt++; if (s_haddr !== 32'h2000) $display("FAIL bl0_addr got=%h exp=00002000", s_haddr); else pass_cnt++;
      tick(); drive_m(1, 1'b1, SQ, 32'h2004, 1'b0, INCR4); exp_q.push_back({1'b0, 32'h2004});
      drive_m(0, 1'b1, NS, 32'h2100, 1'b1, SINGLE);
      smp();
      total_cnt++; if (s_haddr !== 32'h2004) $display("FAIL bl1_addr got=%h exp=00002004", s_haddr); else pass_cnt++;
      tick(); drive_m(1, 1'b1, SQ, 32'h2008, 1'b0, INCR4); exp_q.push_back({1'b0, 32'h2008});
      idle_m(0); s_hrdata = 32'hDEAD_0004;
      smp();
      total_cnt++; if (s_haddr !== 32'h2008) $display("FAIL bl2_addr got=%h exp=00002008", s_haddr); else pass_cnt++;
      total_cnt++; if (m_hready[0] !== 1'b0) $display("FAIL bl2_rdy0 got=%b exp=0", m_hready[0]); else pass_cnt++;
      total_cnt++; if (m_hrdata !== 64'hDEAD_0004_0000_0000) $display("FAIL bl2_rdata got=%h exp=dead000400000000", m_hrdata); else pass_cnt++;
      tick(); drive_m(1, 1'b1, SQ, 32'h200C, 1'b0, INCR4); exp_q.push_back({1'b0, 32'h200C});
      smp();
      total_cnt++; if (s_haddr !== 32'h200C) $display("FAIL bl3_addr got=%h exp=0000200c", s_haddr); else pass_cnt++;
      tick(); idle_m(1); exp_q.push_back({1'b1, 32'h2100});
      smp();
      total_cnt++; if (s_haddr !== 32'h2100) $display("FAIL bl4_addr got=%h exp=00002100", s_haddr); else pass_cnt++;
      total_cnt++; if (m_hready[0] !== 1'b0) $display("FAIL bl4_rdy0 got=%b exp=0", m_hready[0]); else pass_cnt++;
      tick(); smp();
      total_cnt++; if (m_hready[0] !== 1'b1) $display("FAIL bl5_rdy0 got=%b exp=1", m_hready[0]); else pass_cnt++;
      tick();
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); total_cnt++;
         if (obs_q.size() == 0) $display("FAIL bl_sb got=none exp=%h", e);
         else begin o = obs_q.pop_front(); if (o !== e) $display("FAIL bl_sb got=%h exp=%h", o, e); else pass_cnt++; end
      end
      total_cnt++; if (obs_q.size() != 0) $display("FAIL bl_sb_extra got=%0d exp=0", obs_q.size()); else pass_cnt++;
      obs_q.delete();
      $display("test_burst_lock done");
   endtask

   task automatic test_wait_state();
      logic [32:0] e, o;
      tick(); drive_m(0, 1'b1, NS, 32'h4000, 1'b1, SINGLE); exp_q.push_back({1'b1, 32'h4000});
      smp();
      total_cnt++; if (s_haddr !== 32'h4000) $display("FAIL ws0_addr got=%h exp=00004000", s_haddr); else pass_cnt++;
      tick(); idle_m(0); m_hwdata[31:0] = 32'hBEEF_0001; s_hready = 1'b0;
      drive_m(1, 1'b1, NS, 32'h5000, 1'b0, SINGLE);
      smp();
      total_cnt++; if (m_hready !== 2'b10) $display("FAIL ws1_rdy got=%b exp=10", m_hready); else pass_cnt++;
      total_cnt++; if (s_haddr !== 32'h4000) $display("FAIL ws1_addr got=%h exp=00004000", s_haddr); else pass_cnt++;
      tick(); idle_m(1);
      smp();
      total_cnt++; if (m_hready !== 2'b00) $display("FAIL ws2_rdy got=%b exp=00", m_hready); else pass_cnt++;
      total_cnt++; if (s_haddr !== 32'h4000) $display("FAIL ws2_addr got=%h exp=00004000", s_haddr); else pass_cnt++;
      tick(); smp();
      total_cnt++; if (m_hready !== 2'b00) $display("FAIL ws3_rdy got=%b exp=00", m_hready); else pass_cnt++;
      total_cnt++; if (s_haddr !== 32'h4000) $display("FAIL ws3_addr got=%h exp=00004000", s_haddr); else pass_cnt++;
      total_cnt++; if (s_hwdata !== 32'hBEEF_0001) $display("FAIL ws3_wdata got=%h exp=beef0001", s_hwdata); else pass_cnt++;
      tick(); s_hready = 1'b1; exp_q.push_back({1'b0, 32'h5000});
      smp();
      total_cnt++; if (m_hready[0] !== 1'b1) $display("FAIL ws4_rdy0 got=%b exp=1", m_hready[0]); else pass_cnt++;
      total_cnt++; if (s_haddr !== 32'h5000) $display("FAIL ws4_addr got=%h exp=00005000", s_haddr); else pass_cnt++;
      tick(); smp();
      total_cnt++; if (m_hready !== 2'b11) $display("FAIL ws5_rdy got=%b exp=11", m_hready); else pass_cnt++;
      tick();
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); total_cnt++;
         if (obs_q.size() == 0) $display("FAIL ws_sb got=none exp=%h", e);
         else begin o = obs_q.pop_front(); if (o !== e) $display("FAIL ws_sb got=%h exp=%h", o, e); else pass_cnt++; end
      end
      total_cnt++; if (obs_q.size() != 0) $display("FAIL ws_sb_extra got=%0d exp=0", obs_q.size()); else pass_cnt++;
      obs_q.delete();
      $display("test_wait_state done");
   endtask

   task automatic test_error();
      logic [32:0] e, o;
      tick(); drive_m(0, 1'b1, NS, 32'h3000, 1'b0, SINGLE); exp_q.push_back({1'b0, 32'h3000});
      smp();
      total_cnt++; if (s_haddr !== 32'h3000) $display("FAIL er0_addr got=%h exp=00003000", s_haddr); else pass_cnt++;
      tick(); drive_m(0, 1'b1, NS, 32'h3004, 1'b0, SINGLE); s_hready = 1'b0; s_hresp = 1'b1;
      smp();
      total_cnt++; if (m_hresp !== 2'b01) $display("FAIL er1_resp got=%b exp=01", m_hresp); else pass_cnt++;
      total_cnt++; if (m_hready[0] !== 1'b0) $display("FAIL er1_rdy0 got=%b exp=0", m_hready[0]); else pass_cnt++;
      tick(); idle_m(0); s_hready = 1'b1;
      smp();
      total_cnt++; if (m_hresp !== 2'b01) $display("FAIL er2_resp got=%b exp=01", m_hresp); else pass_cnt++;
      total_cnt++; if (s_htrans !== IDLE) $display("FAIL er2_htrans got=%b exp=00", s_htrans); else pass_cnt++;
      tick(); s_hresp = 1'b0;
      smp();
      total_cnt++; if (m_hready !== 2'b11) $display("FAIL er3_rdy got=%b exp=11", m_hready); else pass_cnt++;
      total_cnt++; if (m_hresp !== 2'b00) $display("FAIL er3_resp got=%b exp=00", m_hresp); else pass_cnt++;
      tick();
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); total_cnt++;
         if (obs_q.size() == 0) $display("FAIL er_sb got=none exp=%h", e);
         else begin o = obs_q.pop_front(); if (o !== e) $display("FAIL er_sb got=%h exp=%h", o, e); else pass_cnt++; end
      end
      total_cnt++; if (obs_q.size() != 0) $display("FAIL er_sb_extra got=%0d exp=0", obs_q.size()); else pass_cnt++;
      obs_q.delete();
      $display("test_error done");
   endtask

   task automatic test_clk_ratio();
      logic [32:0] e, o;
      tick(); drive_m(0, 1'b1, NS, 32'h6000, 1'b0, INCR4); exp_q.push_back({1'b0, 32'h6000});
      smp();
      total_cnt++; if (s_clk_ratio !== 4'd1) $display("FAIL cr0_ratio got=%0d exp=1", s_clk_ratio); else pass_cnt++;
      tick(); drive_m(0, 1'b1, SQ, 32'h6004, 1'b0, INCR4); exp_q.push_back({1'b0, 32'h6004});
      cfg_clk_ratio = 4'd9; cfg_clk_ratio_vld = 1'b1;
      tick(); drive_m(0, 1'b1, SQ, 32'h6008, 1'b0, INCR4); exp_q.push_back({1'b0, 32'h6008});
      cfg_clk_ratio = 4'd3;
      smp();
      total_cnt++; if (s_clk_ratio !== 4'd1) $display("FAIL cr2_ratio got=%0d exp=1", s_clk_ratio); else pass_cnt++;
      tick(); drive_m(0, 1'b1, SQ, 32'h600C, 1'b0, INCR4); exp_q.push_back({1'b0, 32'h600C});
      cfg_clk_ratio_vld = 1'b0;
      smp();
      total_cnt++; if (s_clk_ratio !== 4'd1) $display("FAIL cr3_ratio got=%0d exp=1", s_clk_ratio); else pass_cnt++;
      tick(); idle_m(0);
      smp();
      total_cnt++; if (s_clk_ratio !== 4'd1) $display("FAIL cr4_ratio got=%0d exp=1", s_clk_ratio); else pass_cnt++;
      tick(); smp();
      total_cnt++; if (s_clk_ratio !== 4'd1) $display("FAIL cr5_ratio got=%0d exp=1", s_clk_ratio); else pass_cnt++;
      tick(); smp();
      total_cnt++; if (s_clk_ratio !== 4'd3) $display("FAIL cr6_ratio got=%0d exp=3", s_clk_ratio); else pass_cnt++;
      tick();
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); total_cnt++;
         if (obs_q.size() == 0) $display("FAIL cr_sb got=none exp=%h", e);
         else begin o = obs_q.pop_front(); if (o !== e) $display("FAIL cr_sb got=%h exp=%h", o, e); else pass_cnt++; end
      end
      total_cnt++; if (obs_q.size() != 0) $display("FAIL cr_sb_extra got=%0d exp=0", obs_q.size()); else pass_cnt++;
      obs_q.delete();
      $display("test_clk_ratio done");
   endtask

   task automatic test_reset_mid();
      logic [32:0] e, o;
      tick(); drive_m(1, 1'b1, NS, 32'h7000, 1'b0, INCR4); exp_q.push_back({1'b0, 32'h7000});
      smp();
      total_cnt++; if (s_haddr !== 32'h7000) $display("FAIL rm0_addr got=%h exp=00007000", s_haddr); else pass_cnt++;
      tick(); drive_m(1, 1'b1, SQ, 32'h7004, 1'b0, INCR4); exp_q.push_back({1'b0, 32'h7004});
      drive_m(0, 1'b1, NS, 32'h7100, 1'b0, SINGLE);
      cfg_clk_ratio = 4'd6; cfg_clk_ratio_vld = 1'b1;
      tick(); drive_m(1, 1'b1, SQ, 32'h7008, 1'b0, INCR4); idle_m(0);
      cfg_clk_ratio_vld = 1'b0; hreset = 1'b1;
      smp();
      total_cnt++; if (m_hready[0] !== 1'b0) $display("FAIL rm2_rdy0 got=%b exp=0", m_hready[0]); else pass_cnt++;
      tick(); hreset = 1'b0; idle_m(1); s_hrdata = 32'hFFFF_0000;
      smp();
      total_cnt++; if (m_hready !== 2'b11) $display("FAIL rm3_rdy got=%b exp=11", m_hready); else pass_cnt++;
      total_cnt++; if (s_htrans !== IDLE) $display("FAIL rm3_htrans got=%b exp=00", s_htrans); else pass_cnt++;
      total_cnt++; if (s_hsel !== 1'b0) $display("FAIL rm3_hsel got=%b exp=0", s_hsel); else pass_cnt++;
      total_cnt++; if (s_haddr !== 32'h0) $display("FAIL rm3_haddr got=%h exp=0", s_haddr); else pass_cnt++;
      total_cnt++; if (m_hrdata !== 64'h0) $display("FAIL rm3_rdata got=%h exp=0", m_hrdata); else pass_cnt++;
      total_cnt++; if (s_clk_ratio !== 4'd1) $display("FAIL rm3_ratio got=%0d exp=1", s_clk_ratio); else pass_cnt++;
      tick(); tick(); tick(); smp();
      total_cnt++; if (s_clk_ratio !== 4'd1) $display("FAIL rm6_ratio got=%0d exp=1", s_clk_ratio); else pass_cnt++;
      total_cnt++; if (s_htrans !== IDLE) $display("FAIL rm6_htrans got=%b exp=00", s_htrans); else pass_cnt++;
      tick();
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); total_cnt++;
         if (obs_q.size() == 0) $display("FAIL rm_sb got=none exp=%h", e);
         else begin o = obs_q.pop_front(); if (o !== e) $display("FAIL rm_sb got=%h exp=%h", o, e); else pass_cnt++; end
      end
      total_cnt++; if (obs_q.size() != 0) $display("FAIL rm_sb_extra got=%0d exp=0", obs_q.size()); else pass_cnt++;
      obs_q.delete();
      $display("test_reset_mid done");
   endtask

   initial begin
      test_reset();
      test_single_write();
      test_tie();
      test_burst_lock();
      test_wait_state();
      test_error();
      test_clk_ratio();
      test_reset_mid();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule

// File: doc/ahbl_arbiter.md
# ahbl_arbiter

Round-robin AHB-Lite arbiter and multiplexer sharing one AHB-Lite slave port, the bridge's AHB side, between `NUM_MST` AHB-Lite masters. Each master port has a one-entry address-phase holding stage, so a master that loses arbitration is stalled through its own `hready` and needs no bus-request signals. The block also owns the bridge's `clk_ratio` configuration and applies updates only while the shared bus is quiescent.

## Interface
- `NUM_MST`, 2: number of master ports, legal 2..4.
- `CLK_RATIO_RST`, 4'd1: reset value of `s_clk_ratio`.
- `hclk`  in  1: clock, rising edge.
- `hreset`  in  1: reset. One clock; reset is synchronous and active-high.
- Per-master vectors, slice i for master i:
  - `m_hsel`  in  NUM_MST: select.
  - `m_haddr`  in  32·NUM_MST: address.
  - `m_htrans`  in  2·NUM_MST: transfer type.
  - `m_hsize`  in  3·NUM_MST: size.
  - `m_hburst`  in  3·NUM_MST: burst.
  - `m_hprot`  in  4·NUM_MST: protection.
  - `m_hwrite`  in  NUM_MST: write.
  - `m_hwdata`  in  32·NUM_MST: write data.
  - `m_hrdata`  out  32·NUM_MST: read data.
  - `m_hready`  out  NUM_MST: ready.
  - `m_hresp`  out  NUM_MST: response.
- Slave side:
  - `s_hsel`, `s_haddr`, `s_htrans`, `s_hsize`, `s_hburst`, `s_hprot`, `s_hwrite`, `s_hwdata`  out: standard widths.
  - `s_hrdata`  in  32.
  - `s_hready`  in  1.
  - `s_hresp`  in  1.
- `cfg_clk_ratio`  in  4: requested ratio.
- `cfg_clk_ratio_vld`  in  1: one-cycle update strobe.
- `s_clk_ratio`  out  4: applied ratio.

## Operation
- **Request.** Master i requests when `m_hsel[i]`=1 and `m_htrans[i]` is NONSEQ or SEQ while `m_hready[i]`=1, or when its holding register is valid (`pend[i]`).
- **Source selection.** The request source is the holding register when `pend[i]`=1, otherwise the live inputs.
- **Arbitration.** Evaluated only in cycles where `s_hready`=1.
  - Round-robin pointer `rr_last`; the search starts at `rr_last+1` mod `NUM_MST`.
  - Reset value `NUM_MST-1`, so master 0 wins first.
- **Burst lock.** While the current owner's next address phase is SEQ or BUSY, ownership does not change. The lock releases when the owner drives IDLE or NONSEQ.
- **Winner.** Its source drives the slave address phase combinationally. `rr_last` updates to the winner, and `pend[winner]` clears.
- **Loser.** A requesting master that does not win, or any request in a cycle with `s_hready`=0, is captured into its holding register (`pend[i]`=1).
- **No requester.** `s_htrans`=IDLE and `s_hsel`=0.
- **Data-phase owner.** `dp_vld` and `dp_own` are set from the accepted address phase when `s_hready`=1.
  - Only the owner receives `s_hrdata`, `s_hready` and `s_hresp`.
  - `s_hwdata` is `m_hwdata[dp_own]`.
- **Non-owner masters.** `m_hready[i] = ~pend[i]` and `m_hresp[i]` = OKAY.
- **Error response.** The two-cycle ERROR is forwarded unchanged to the owner. If the owner cancels with IDLE in the second cycle, that IDLE reaches the slave and no held entry is created.
- **Clock ratio.** A `cfg_clk_ratio_vld` strobe loads a shadow register and sets `ratio_pend`.
  - The shadow value is copied to `s_clk_ratio` on the first cycle where `dp_vld`=0, no `pend` bit is set and no request is present. `ratio_pend` clears on that copy.
  - A new strobe before the copy overwrites the shadow; the last value wins.

## Timing
- **Reset values.** `s_hsel`=0, `s_htrans`=IDLE, all other `s_*` address and control outputs 0, `m_hready`=all 1, `m_hresp`=OKAY, `m_hrdata`=0, `pend`=0, `dp_vld`=0, `s_clk_ratio`=`CLK_RATIO_RST`, `ratio_pend`=0.
- **Uncontended transfer.** Zero added latency; the address phase passes through in the same cycle.
- **Losing master.** Its `m_hready` is low from the cycle after capture until its held transfer's data phase completes. The held transfer is issued no earlier than the cycle after the winner's last locked beat is accepted.
- **Stall stability.** While `s_hready`=0, all `s_*` address-phase outputs hold stable.
- **Reset during operation.** A reset mid-burst or mid-stall drops all held and in-flight state at the next edge. No transfer is replayed.

## Test plan
- **Single write, master 0.** NONSEQ write to 0x1000, data 0xA5A5_0001, `s_hready`=1 → `s_haddr`=0x1000 in the same cycle, `s_hwdata`=0xA5A5_0001 the next cycle, `m_hready[0]` never low.
- **Simultaneous NONSEQ, first tie.** Master 0 and master 1 issue NONSEQ at cycle N → master 0 on the slave at N, master 1 on the slave at N+1, `m_hready[1]`=0 for one cycle. On the next tie master 1 wins.
- **Burst lock.** Master 1 runs an INCR4 reading 0x2000..0x200C while master 0 requests at beat 2 → master 0 address appears only after the 0x200C beat is accepted.
- **Slave wait state.** `s_hready`=0 for 3 cycles during master 0's data phase → the owner sees `hready` low for those 3 cycles, `s_haddr` stays stable, and master 1's live request is captured with no loss.
- **Error response.** Master 0 reads 0x3000, slave returns ERROR for two cycles → only `m_hresp[0]`=1 for two cycles; master 0's IDLE in the second cycle yields `s_htrans`=IDLE.
- **Clock-ratio update and reset.** Ratio strobe 4'd3 during a burst → `s_clk_ratio` changes only on the first idle cycle. `hreset` pulsed mid-burst → all outputs return to their reset values on the next edge.
